pcie_cfg_mgmt_master: RTL and testbench
=======================================

# pcie_cfg_mgmt_master

Sequencer for the UltraScale+ PCIe hard-block configuration management port. It converts a valid/ready request stream from core logic into the level-held `cfg_mgmt_read`/`cfg_mgmt_write` strobes, waits for `cfg_mgmt_read_write_done`, and returns a valid/ready response carrying read data and completion status. It sits between `fpga_core` and the `cfg_mgmt_*` pins of the PCIe IP instance. It guarantees one outstanding access and a bounded wait via a timeout.

## Interface

Parameters:
- `TIMEOUT`, 1024: cycles to wait for done before aborting; legal range 2..65535.
- `CNT_WIDTH`, 16: width of the timeout counter; must hold `TIMEOUT`.

Ports:
- `clk` in 1: PCIe user clock, 250 MHz.
- `rst_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `s_req_addr` in 10: DWORD config address.
- `s_req_func` in 8: function number.
- `s_req_write` in 1: 1 = write, 0 = read.
- `s_req_data` in 32: write data.
- `s_req_be` in 4: byte enables.
- `s_req_valid` in 1, `s_req_ready` out 1: request handshake.
- `m_resp_data` out 32: read data; 0 for writes and timeouts.
- `m_resp_write` out 1: echo of the request type.
- `m_resp_timeout` out 1: 1 = access aborted by timeout.
- `m_resp_valid` out 1, `m_resp_ready` in 1: response handshake.
- `cfg_mgmt_addr` out 10, `cfg_mgmt_function_number` out 8, `cfg_mgmt_write_data` out 32, `cfg_mgmt_byte_enable` out 4: registered request fields.
- `cfg_mgmt_write` out 1, `cfg_mgmt_read` out 1: access strobes.
- `cfg_mgmt_read_data` in 32, `cfg_mgmt_read_write_done` in 1: from the IP.
- `stat_timeout` out 1: one-cycle pulse per timeout abort.

## Operation

- FSM states:
  - `IDLE`: `s_req_ready`=1. On `s_req_valid`, latch all fields into the `cfg_mgmt_*` registers, clear the counter, and go to `ACCESS`.
  - `ACCESS`: exactly one of `cfg_mgmt_read`/`cfg_mgmt_write` is held at 1 throughout the state.
    - On `cfg_mgmt_read_write_done`=1: drop the strobe, capture `cfg_mgmt_read_data` (reads only), set `m_resp_timeout`=0, and go to `RESP`.
    - Otherwise, if the counter equals `TIMEOUT-1`: drop the strobe, set `m_resp_data`=0 and `m_resp_timeout`=1, pulse `stat_timeout`, and go to `RESP`.
    - Otherwise the counter increments by 1.
  - `RESP`: `m_resp_valid`=1 and all response fields are stable. On `m_resp_ready`, go to `IDLE`.
- A done pulse that arrives while in `IDLE` or `RESP` is ignored and produces no response.
- Done and timeout in the same cycle: done wins and the response has `m_resp_timeout`=0.
- Address, function, data and byte-enable outputs hold their last value outside `ACCESS`.
- The counter never wraps; it saturates at the abort point.
- Reset mid-operation: all state returns to the reset values immediately (asynchronously). Any in-flight access is dropped with no response.

## Timing

- Reset values:
  - FSM = `IDLE`, `s_req_ready`=1 (combinational from state).
  - `m_resp_valid`=0, `m_resp_data`=0, `m_resp_write`=0, `m_resp_timeout`=0.
  - `cfg_mgmt_read`=0, `cfg_mgmt_write`=0, `cfg_mgmt_addr`=0, `cfg_mgmt_function_number`=0, `cfg_mgmt_write_data`=0, `cfg_mgmt_byte_enable`=0.
  - `stat_timeout`=0, counter=0.
- Request accepted at edge N → strobe high from cycle N+1.
- Done sampled high at edge M → strobe low and `m_resp_valid` high from cycle M+1.
- Strobe first high at cycle N+1 with no done → abort at edge N+`TIMEOUT`. The strobe is high for exactly `TIMEOUT` cycles.
- Response accepted at edge R → `s_req_ready` high in cycle R+1. There is no bypass, so the back-to-back access period is at least 3 cycles plus the IP latency.
- `s_req_ready`=0 in `ACCESS` and `RESP`.

## Test plan

- Read, addr 0x004, func 0, done asserted 3 cycles after strobe rise with read data 0xDEADBEEF:
  - `cfg_mgmt_read` high for exactly 3 cycles.
  - Response `m_resp_data`=0xDEADBEEF, `m_resp_timeout`=0, `m_resp_write`=0, one cycle after done.
- Write, addr 0x010, data 0x12345678, BE 0xF, done after 1 cycle:
  - `cfg_mgmt_write_data`=0x12345678 and `cfg_mgmt_write`=1 for exactly 1 cycle.
  - Response `m_resp_data`=0, `m_resp_write`=1.
- `TIMEOUT`=8, read, done never asserted:
  - Strobe high for exactly 8 cycles.
  - Response `m_resp_timeout`=1, `m_resp_data`=0.
  - `stat_timeout` pulses once.
- `TIMEOUT`=8, done asserted in the 8th strobe cycle: response `m_resp_timeout`=0 with the captured data, and no `stat_timeout` pulse.
- Backpressure and stray done:
  - Hold `m_resp_ready`=0 for 10 cycles: `m_resp_valid` and the data stay stable, and `s_req_ready` stays 0.
  - A stray done pulse in `RESP` changes nothing.
  - Next request is accepted one cycle after the response handshake.
- Reset mid-access: deassert `rst_n` 2 cycles into `ACCESS`.
  - Strobes go to 0 asynchronously and `m_resp_valid` stays 0.
  - After release, `s_req_ready`=1 and a new read completes normally.

Source files
------------

// File: rtl/pcie_cfg_mgmt_master.sv
// Sequencer for the PCIe configuration management port: one outstanding access,
// level-held read/write strobes and a bounded wait for done with timeout abort.
module pcie_cfg_mgmt_master #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  s_req_addr,
    input  logic [7:0]  s_req_func,
    input  logic        s_req_write,
    input  logic [31:0] s_req_data,
    input  logic [3:0]  s_req_be,
    input  logic        s_req_valid,
    output logic        s_req_ready,
    output logic [31:0] m_resp_data,
    output logic        m_resp_write,
    output logic        m_resp_timeout,
    output logic        m_resp_valid,
    input  logic        m_resp_ready,
    output logic [9:0]  cfg_mgmt_addr,
    output logic [7:0]  cfg_mgmt_function_number,
    output logic [31:0] cfg_mgmt_write_data,
    output logic [3:0]  cfg_mgmt_byte_enable,
    output logic        cfg_mgmt_write,
    output logic        cfg_mgmt_read,
    input  logic [31:0] cfg_mgmt_read_data,
    input  logic        cfg_mgmt_read_write_done,
    output logic        stat_timeout
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT - 1);

    state_e               r_state;
    state_e               w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [9:0]           r_addr;
    logic [7:0]           r_func;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;
    logic                 r_write;
    logic [31:0]          r_resp_data;
    logic                 r_resp_write;
    logic                 r_resp_timeout;
    logic                 r_stat_timeout;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_abort;

    assign w_accept = (r_state == StIdle) && s_req_valid;
    assign w_done   = (r_state == StAccess) && cfg_mgmt_read_write_done;
    // Done wins over a coincident timeout.
    assign w_abort  = (r_state == StAccess) && !cfg_mgmt_read_write_done && (r_cnt == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (s_req_valid) w_state_next = StAccess;
            StAccess: if (w_done || w_abort) w_state_next = StResp;
            StResp:   if (m_resp_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        s_req_ready    = (r_state == StIdle);
        m_resp_valid   = (r_state == StResp);
        cfg_mgmt_read  = (r_state == StAccess) && !r_write;
        cfg_mgmt_write = (r_state == StAccess) && r_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_addr         <= '0;
            r_func         <= '0;
            r_wdata        <= '0;
            r_be           <= '0;
            r_write        <= 1'b0;
            r_resp_data    <= '0;
            r_resp_write   <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_stat_timeout <= 1'b0;
        end else begin
            r_stat_timeout <= w_abort;
            if (w_accept) begin
                r_cnt   <= '0;
                r_addr  <= s_req_addr;
                r_func  <= s_req_func;
                r_wdata <= s_req_data;
                r_be    <= s_req_be;
                r_write <= s_req_write;
            end else if (r_state == StAccess && r_cnt != CntLast) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done) begin
                r_resp_data    <= r_write ? 32'h0 : cfg_mgmt_read_data;
                r_resp_write   <= r_write;
                r_resp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_resp_data    <= 32'h0;
                r_resp_write   <= r_write;
                r_resp_timeout <= 1'b1;
            end
        end
    end

    assign cfg_mgmt_addr            = r_addr;
    assign cfg_mgmt_function_number = r_func;
    assign cfg_mgmt_write_data      = r_wdata;
    assign cfg_mgmt_byte_enable     = r_be;
    assign m_resp_data              = r_resp_data;
    assign m_resp_write             = r_resp_write;
    assign m_resp_timeout           = r_resp_timeout;
    assign stat_timeout             = r_stat_timeout;

endmodule

// File: tb/tb_pcie_cfg_mgmt_master.sv
// Bench for pcie_cfg_mgmt_master: directed vector table, random accesses against a
// reference model, and hand sequences for backpressure, stray done and reset.
module tb_pcie_cfg_mgmt_master;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst_n;
    logic [9:0]  s_req_addr;
    logic [7:0]  s_req_func;
    logic        s_req_write;
    logic [31:0] s_req_data;
    logic [3:0]  s_req_be;
    logic        s_req_valid;
    logic        s_req_ready;
    logic [31:0] m_resp_data;
    logic        m_resp_write;
    logic        m_resp_timeout;
    logic        m_resp_valid;
    logic        m_resp_ready;
    logic [9:0]  cfg_mgmt_addr;
    logic [7:0]  cfg_mgmt_function_number;
    logic [31:0] cfg_mgmt_write_data;
    logic [3:0]  cfg_mgmt_byte_enable;
    logic        cfg_mgmt_write;
    logic        cfg_mgmt_read;
    logic [31:0] cfg_mgmt_read_data;
    logic        cfg_mgmt_read_write_done;
    logic        stat_timeout;

    int checks = 0;
    int errors = 0;
    int stat_cnt = 0;

    pcie_cfg_mgmt_master #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(16)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .s_req_addr               (s_req_addr),
        .s_req_func               (s_req_func),
        .s_req_write              (s_req_write),
        .s_req_data               (s_req_data),
        .s_req_be                 (s_req_be),
        .s_req_valid              (s_req_valid),
        .s_req_ready              (s_req_ready),
        .m_resp_data              (m_resp_data),
        .m_resp_write             (m_resp_write),
        .m_resp_timeout           (m_resp_timeout),
        .m_resp_valid             (m_resp_valid),
        .m_resp_ready             (m_resp_ready),
        .cfg_mgmt_addr            (cfg_mgmt_addr),
        .cfg_mgmt_function_number (cfg_mgmt_function_number),
        .cfg_mgmt_write_data      (cfg_mgmt_write_data),
        .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
        .cfg_mgmt_write           (cfg_mgmt_write),
        .cfg_mgmt_read            (cfg_mgmt_read),
        .cfg_mgmt_read_data       (cfg_mgmt_read_data),
        .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done),
        .stat_timeout             (stat_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (stat_timeout) stat_cnt <= stat_cnt + 1;
    end

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [7:0]  func;
        logic [31:0] data;
        logic [3:0]  be;
        int          d;        // strobe cycle in which done is raised, 0 = never
        logic [31:0] rd;
        int          exp_cyc;
        logic [31:0] exp_data;
        logic        exp_to;
        int          exp_stat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: done inside the strobe window completes, anything else times out.
    function automatic void model(input logic wr, input int d, input logic [31:0] rd,
                                  output int cyc, output logic [31:0] data, output logic to);
        if (d >= 1 && d <= TIMEOUT) begin
            cyc  = d;
            to   = 1'b0;
            data = wr ? 32'h0 : rd;
        end else begin
            cyc  = TIMEOUT;
            to   = 1'b1;
            data = 32'h0;
        end
    endfunction

    task automatic issue(input logic wr, input logic [9:0] addr, input logic [7:0] func,
                         input logic [31:0] data, input logic [3:0] be);
        int n = 0;
        while (!s_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", {31'h0, s_req_ready}, 32'h1);
        s_req_write = wr;
        s_req_addr  = addr;
        s_req_func  = func;
        s_req_data  = data;
        s_req_be    = be;
        s_req_valid = 1'b1;
        @(posedge clk); #1;
        s_req_valid = 1'b0;
    endtask

    task automatic strobe_phase(input logic wr, input int d, input logic [31:0] rd,
                                output int cnt, output int bad);
        cnt = 0;
        bad = 0;
        for (int c = 1; c <= TIMEOUT + 3; c++) begin
            if (!(cfg_mgmt_read || cfg_mgmt_write)) break;
            cnt++;
            if ({cfg_mgmt_write, cfg_mgmt_read} != (wr ? 2'b10 : 2'b01)) bad++;
            cfg_mgmt_read_data       = rd;
            cfg_mgmt_read_write_done = (c == d);
            @(posedge clk); #1;
            cfg_mgmt_read_write_done = 1'b0;
        end
    endtask

    task automatic handshake();
        m_resp_ready = 1'b1;
        @(posedge clk); #1;
        m_resp_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int hold);
        int cnt;
        int bad;
        int s0;
        s0 = stat_cnt;
        issue(v.wr, v.addr, v.func, v.data, v.be);
        check({tag, ".addr"}, {22'h0, cfg_mgmt_addr}, {22'h0, v.addr});
        check({tag, ".func"}, {24'h0, cfg_mgmt_function_number}, {24'h0, v.func});
        check({tag, ".wdata"}, cfg_mgmt_write_data, v.data);
        check({tag, ".be"}, {28'h0, cfg_mgmt_byte_enable}, {28'h0, v.be});
        strobe_phase(v.wr, v.d, v.rd, cnt, bad);
        check({tag, ".strobe_cycles"}, cnt, v.exp_cyc);
        check({tag, ".strobe_kind"}, bad, 0);
        for (int i = 0; i <= hold; i++) begin
            check({tag, ".resp_valid"}, {31'h0, m_resp_valid}, 32'h1);
            check({tag, ".resp_data"}, m_resp_data, v.exp_data);
            check({tag, ".resp_write"}, {31'h0, m_resp_write}, {31'h0, v.wr});
            check({tag, ".resp_timeout"}, {31'h0, m_resp_timeout}, {31'h0, v.exp_to});
            check({tag, ".req_ready_busy"}, {31'h0, s_req_ready}, 32'h0);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        check({tag, ".addr_hold"}, {22'h0, cfg_mgmt_addr}, {22'h0, v.addr});
        handshake();
        check({tag, ".stat_pulses"}, stat_cnt - s0, v.exp_stat);
        check({tag, ".idle_ready"}, {31'h0, s_req_ready}, 32'h1);
        check({tag, ".idle_valid"}, {31'h0, m_resp_valid}, 32'h0);
    endtask

    initial begin
        int cnt;
        int bad;
        vec_t v;

        vecs[0] = '{1'b0, 10'h004, 8'h00, 32'h0, 4'hF, 3, 32'hDEADBEEF,
                    3, 32'hDEADBEEF, 1'b0, 0};
        vecs[1] = '{1'b1, 10'h010, 8'h00, 32'h12345678, 4'hF, 1, 32'hFFFFFFFF,
                    1, 32'h0, 1'b0, 0};
        vecs[2] = '{1'b0, 10'h3FF, 8'h07, 32'h0, 4'h3, 0, 32'hA5A5A5A5,
                    8, 32'h0, 1'b1, 1};
        vecs[3] = '{1'b0, 10'h123, 8'h02, 32'h0, 4'h1, 8, 32'hCAFEF00D,
                    8, 32'hCAFEF00D, 1'b0, 0};
        vecs[4] = '{1'b1, 10'h2A0, 8'hFF, 32'h0BADF00D, 4'hC, 0, 32'h5A5A5A5A,
                    8, 32'h0, 1'b1, 1};

        rst_n = 1'b0;
        s_req_addr = '0; s_req_func = '0; s_req_write = 1'b0; s_req_data = '0;
        s_req_be = '0; s_req_valid = 1'b0; m_resp_ready = 1'b0;
        cfg_mgmt_read_data = '0; cfg_mgmt_read_write_done = 1'b0;
        #2;
        check("rst.req_ready", {31'h0, s_req_ready}, 32'h1);
        check("rst.resp_valid", {31'h0, m_resp_valid}, 32'h0);
        check("rst.resp_data", m_resp_data, 32'h0);
        check("rst.resp_flags", {30'h0, m_resp_write, m_resp_timeout}, 32'h0);
        check("rst.strobes", {30'h0, cfg_mgmt_write, cfg_mgmt_read}, 32'h0);
        check("rst.fields", {cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_byte_enable},
              32'h0);
        check("rst.wdata", cfg_mgmt_write_data, 32'h0);
        check("rst.stat", {31'h0, stat_timeout}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

        for (int i = 0; i < 40; i++) begin
            v.wr   = 1'($urandom_range(0, 1));
            v.addr = 10'($urandom);
            v.func = 8'($urandom);
            v.data = $urandom;
            v.be   = 4'($urandom);
            v.d    = $urandom_range(0, TIMEOUT + 2);
            v.rd   = $urandom;
            model(v.wr, v.d, v.rd, v.exp_cyc, v.exp_data, v.exp_to);
            v.exp_stat = v.exp_to ? 1 : 0;
            run_vec($sformatf("rnd%0d", i), v, $urandom_range(0, 3));
        end

        // Backpressure with a stray done and a waiting request.
        issue(1'b0, 10'h044, 8'h01, 32'h0, 4'hF);
        strobe_phase(1'b0, 2, 32'h11223344, cnt, bad);
        check("bp.strobe_cycles", cnt, 2);
        s_req_write = 1'b1; s_req_addr = 10'h020; s_req_func = 8'h03;
        s_req_data = 32'h55AA55AA; s_req_be = 4'h5; s_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cfg_mgmt_read_data       = 32'h99999999;
            cfg_mgmt_read_write_done = (i == 4);
            check("bp.valid", {31'h0, m_resp_valid}, 32'h1);
            check("bp.data", m_resp_data, 32'h11223344);
            check("bp.timeout", {31'h0, m_resp_timeout}, 32'h0);
            check("bp.req_ready", {31'h0, s_req_ready}, 32'h0);
            @(posedge clk); #1;
            cfg_mgmt_read_write_done = 1'b0;
        end
        handshake();
        check("bp.next_ready", {31'h0, s_req_ready}, 32'h1);
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        check("bp.next_strobe", {30'h0, cfg_mgmt_write, cfg_mgmt_read}, 32'h2);
        check("bp.next_addr", {22'h0, cfg_mgmt_addr}, 32'h020);
        strobe_phase(1'b1, 1, 32'h0, cnt, bad);
        check("bp.next_cycles", cnt, 1);
        check("bp.next_data", m_resp_data, 32'h0);
        check("bp.next_write", {31'h0, m_resp_write}, 32'h1);
        handshake();

        // Stray done while idle.
        cfg_mgmt_read_write_done = 1'b1;
        @(posedge clk); #1;
        cfg_mgmt_read_write_done = 1'b0;
        @(posedge clk); #1;
        check("idle_done.valid", {31'h0, m_resp_valid}, 32'h0);
        check("idle_done.ready", {31'h0, s_req_ready}, 32'h1);

        // Reset two cycles into an access.
        issue(1'b0, 10'h0AB, 8'h04, 32'h0, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid.pre_strobe", {31'h0, cfg_mgmt_read}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.strobes", {30'h0, cfg_mgmt_write, cfg_mgmt_read}, 32'h0);
        check("rstmid.valid", {31'h0, m_resp_valid}, 32'h0);
        check("rstmid.ready", {31'h0, s_req_ready}, 32'h1);
        check("rstmid.addr", {22'h0, cfg_mgmt_addr}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rstmid.no_resp", {31'h0, m_resp_valid}, 32'h0);
            @(posedge clk); #1;
        end
        v = '{1'b0, 10'h00C, 8'h00, 32'h0, 4'hF, 2, 32'h87654321,
              2, 32'h87654321, 1'b0, 0};
        run_vec("rstmid.after", v, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
